// File: rtl/mx_pkg.sv
// Shared constants and types for the FP32 -> MX E4M3 block sequencing path.
// Field positions follow the IEEE-754 single-precision layout {sign, exp, mant}.
package mx_pkg;

    localparam int FP_SIGN_BIT   = 31;
    localparam int FP_EXP_MSB    = 30;
    localparam int FP_EXP_LSB    = 23;
    localparam int FP_MANT_MSB   = 22;
    localparam int EXP_W         = 8;
    localparam int E4M3_W        = 8;
    localparam int SCALE_W       = 8;

    localparam int BLOCK_SIZE_DEF = 32;
    localparam int IDX_W_DEF      = 5;
    localparam int MANT_KEEP_DEF  = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCALE   = 2'd1,
        EMIT    = 2'd2
    } state_e;

    // Unsigned exponent maximum; 0xFF (Inf/NaN) naturally dominates.
    function automatic logic [EXP_W-1:0] exp_max(input logic [EXP_W-1:0] a,
                                                 input logic [EXP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mx_elem_buf.sv
// Element store for one MX block: BLOCK_SIZE entries of the converter operand form.
// One synchronous write port, one asynchronous read port.
module mx_elem_buf
    import mx_pkg::*;
#(
    parameter int DEPTH = BLOCK_SIZE_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int W     = 13
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port: one element per accepted input beat.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mx_block_sequencer.sv
// Collects BLOCK_SIZE FP32 elements, tracks the shared exponent, then emits one
// scale byte followed by the converter's E4M3 result for each element, in order.
module mx_block_sequencer
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int MANT_KEEP  = MANT_KEEP_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [E4M3_W-1:0]            out_data,
    output logic                         out_is_scale,
    output logic                         out_last,
    output logic [EXP_W+MANT_KEEP:0]     conv_v,
    output logic [SCALE_W-1:0]           conv_x,
    input  logic [E4M3_W-1:0]            conv_p
);

    localparam int V_W = 1 + EXP_W + MANT_KEEP;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    wr_idx_q;
    logic [IDX_W-1:0]    rd_idx_q;
    logic [SCALE_W-1:0]  max_exp_q;
    logic                out_valid_q;
    logic [E4M3_W-1:0]   out_data_q;
    logic                out_is_scale_q;
    logic                out_last_q;

    logic [EXP_W-1:0]    in_exp_s;
    logic [V_W-1:0]      in_v_s;
    logic [SCALE_W-1:0]  new_max_s;
    logic                last_in_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                load_en_s;
    logic                unused_mant_s;

    assign in_exp_s      = in_data[FP_EXP_MSB:FP_EXP_LSB];
    assign in_v_s        = {in_data[FP_SIGN_BIT], in_exp_s, in_data[FP_MANT_MSB -: MANT_KEEP]};
    assign unused_mant_s = ^in_data[FP_MANT_MSB-MANT_KEEP:0];
    assign last_in_s     = (wr_idx_q == LAST_IDX);
    assign new_max_s     = (wr_idx_q == {IDX_W{1'b0}}) ? in_exp_s : exp_max(max_exp_q, in_exp_s);

    // The closing element is held off while the previous block's last beat is
    // still pending, so the scale load can never overwrite an unconsumed beat.
    assign in_ready_s = (state_q == COLLECT) && !(last_in_s && out_valid_q);
    assign accept_s   = in_valid && in_ready_s;
    assign load_en_s  = !out_valid_q || out_ready;

    mx_elem_buf #(
        .DEPTH (BLOCK_SIZE),
        .IDX_W (IDX_W),
        .W     (V_W)
    ) u_elem_buf (
        .clk     (clk),
        .we_i    (accept_s),
        .waddr_i (wr_idx_q),
        .wdata_i (in_v_s),
        .raddr_i (rd_idx_q),
        .rdata_o (conv_v)
    );

    // Sequencer FSM: counters, shared-exponent tracker and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= COLLECT;
            wr_idx_q       <= {IDX_W{1'b0}};
            rd_idx_q       <= {IDX_W{1'b0}};
            max_exp_q      <= {SCALE_W{1'b0}};
            out_valid_q    <= 1'b0;
            out_data_q     <= {E4M3_W{1'b0}};
            out_is_scale_q <= 1'b0;
            out_last_q     <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (load_en_s) begin
                        out_valid_q    <= 1'b0;
                        out_is_scale_q <= 1'b0;
                        out_last_q     <= 1'b0;
                    end
                    if (accept_s) begin
                        wr_idx_q  <= wr_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        max_exp_q <= new_max_s;
                        if (last_in_s) begin
                            state_q        <= SCALE;
                            out_data_q     <= new_max_s;
                            out_is_scale_q <= 1'b1;
                            out_last_q     <= 1'b0;
                            out_valid_q    <= 1'b1;
                        end
                    end
                end
                SCALE: begin
                    if (load_en_s) begin
                        out_data_q     <= conv_p;
                        out_is_scale_q <= 1'b0;
                        out_last_q     <= (rd_idx_q == LAST_IDX);
                        out_valid_q    <= 1'b1;
                        rd_idx_q       <= rd_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        state_q        <= EMIT;
                    end
                end
                EMIT: begin
                    if (load_en_s) begin
                        out_data_q     <= conv_p;
                        out_is_scale_q <= 1'b0;
                        out_last_q     <= (rd_idx_q == LAST_IDX);
                        out_valid_q    <= 1'b1;
                        if (rd_idx_q == LAST_IDX) begin
                            rd_idx_q <= {IDX_W{1'b0}};
                            state_q  <= COLLECT;
                        end else begin
                            rd_idx_q <= rd_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_is_scale = out_is_scale_q;
    assign out_last     = out_last_q;
    assign conv_x       = max_exp_q;

endmodule
